// File: rtl/ocp_slave_fsm_pkg.sv
// Shared OCP encodings and slave state type for ocp_slave_fsm and its helpers.
// Used by both ends of the OCP link, so the encodings live here rather than in a module.
package ocp_slave_fsm_pkg;

  localparam int OCP_ADDR_WIDTH_DEF     = 64;
  localparam int OCP_DATA_WIDTH_DEF     = 8;
  localparam int OCP_MEM_ADDR_WIDTH_DEF = 10;

  typedef enum logic [2:0] {
    MCMD_IDLE = 3'b000,
    MCMD_WR   = 3'b001,
    MCMD_RD   = 3'b010,
    MCMD_RDEX = 3'b011,
    MCMD_RDL  = 3'b100,
    MCMD_WRNP = 3'b101,
    MCMD_WRC  = 3'b110,
    MCMD_BCST = 3'b111
  } mcmd_e;

  typedef enum logic [1:0] {
    SRESP_NULL = 2'b00,
    SRESP_DVA  = 2'b01,
    SRESP_FAIL = 2'b10,
    SRESP_ERR  = 2'b11
  } sresp_e;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_DATA = 3'd1,
    S_WR_MEM  = 3'd2,
    S_RD_MEM  = 3'd3,
    S_RESP    = 3'd4
  } slave_state_e;

endpackage

// File: rtl/ocp_slave_addr_decode.sv
// Combinational window decode: hit when BASE_ADDR <= maddr < BASE_ADDR + 2**MEM_ADDR_WIDTH.
module ocp_slave_addr_decode #(
  parameter int                    ADDR_WIDTH     = 64,
  parameter int                    MEM_ADDR_WIDTH = 10,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0
) (
  input  logic [ADDR_WIDTH-1:0]     maddr,
  output logic                      hit,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr
);

  // One extra bit so the window limit cannot wrap at the top of the address space
  localparam logic [ADDR_WIDTH:0] BASE_EXT = {1'b0, BASE_ADDR};
  localparam logic [ADDR_WIDTH:0] WIN_SIZE =
    {{(ADDR_WIDTH-MEM_ADDR_WIDTH){1'b0}}, 1'b1, {MEM_ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] LIMIT = BASE_EXT + WIN_SIZE;

  logic [ADDR_WIDTH:0] maddr_ext;

  assign maddr_ext = {1'b0, maddr};
  assign hit       = (maddr_ext >= BASE_EXT) && (maddr_ext < LIMIT);
  // Base is window-aligned, so the offset is just the low bits
  assign mem_addr  = maddr[MEM_ADDR_WIDTH-1:0];

endmodule

// File: rtl/ocp_slave_fsm.sv
// OCP slave end translating WR/RD (and WRNP when OCP_SLAVE_WRNP_EN is defined) into single-beat
// local memory accesses; all other commands and out-of-window reads answer ERR.
module ocp_slave_fsm
  import ocp_slave_fsm_pkg::*;
#(
  parameter int                    ADDR_WIDTH     = OCP_ADDR_WIDTH_DEF,
  parameter int                    DATA_WIDTH     = OCP_DATA_WIDTH_DEF,
  parameter int                    MEM_ADDR_WIDTH = OCP_MEM_ADDR_WIDTH_DEF,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0
) (
  input  logic                      Clk,
  input  logic                      reset,
  input  logic                      EnableClk,
  input  logic [2:0]                MCmd,
  input  logic [ADDR_WIDTH-1:0]     MAddr,
  input  logic [DATA_WIDTH-1:0]     MData,
  input  logic                      MDataValid,
  output logic                      SCmdAccept,
  output logic                      SDataAccept,
  output logic [1:0]                SResp,
  output logic [DATA_WIDTH-1:0]     SData,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]     mem_wdata,
  output logic                      mem_we,
  output logic                      mem_re,
  input  logic [DATA_WIDTH-1:0]     mem_rdata,
  input  logic                      mem_ready
);

  slave_state_e              state;
  mcmd_e                     cmd_q;
  logic                      hit_q;
  logic                      dec_hit;
  logic [MEM_ADDR_WIDTH-1:0] dec_addr;
  logic                      cmd_take;

  function automatic logic cmd_is_write(input logic [2:0] cmd);
`ifdef OCP_SLAVE_WRNP_EN
    return (cmd == MCMD_WR) || (cmd == MCMD_WRNP);
`else
    return (cmd == MCMD_WR);
`endif
  endfunction

  ocp_slave_addr_decode #(
    .ADDR_WIDTH     (ADDR_WIDTH),
    .MEM_ADDR_WIDTH (MEM_ADDR_WIDTH),
    .BASE_ADDR      (BASE_ADDR)
  ) u_decode (
    .maddr    (MAddr),
    .hit      (dec_hit),
    .mem_addr (dec_addr)
  );

  assign SCmdAccept  = reset && EnableClk && (state == S_IDLE);
  assign SDataAccept = reset && EnableClk && (state == S_WR_DATA);
  assign cmd_take    = SCmdAccept && (MCmd != MCMD_IDLE);

  // Command attributes held for the data/memory phases; no reset needed, always written on accept
  always_ff @(posedge Clk) begin
    if (cmd_take) begin
      cmd_q <= mcmd_e'(MCmd);
      hit_q <= dec_hit;
    end
  end

  always_ff @(posedge Clk) begin
    if (!reset) begin
      state     <= S_IDLE;
      SResp     <= SRESP_NULL;
      SData     <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
    end else if (EnableClk) begin
      case (state)
        S_IDLE: begin
          if (MCmd != MCMD_IDLE) begin
            mem_addr <= dec_addr;
            if (cmd_is_write(MCmd)) begin
              state <= S_WR_DATA;
            end else if ((MCmd == MCMD_RD) && dec_hit) begin
              mem_re <= 1'b1;
              state  <= S_RD_MEM;
            end else begin
              SResp <= SRESP_ERR;
              state <= S_RESP;
            end
          end
        end
        S_WR_DATA: begin
          if (MDataValid) begin
            mem_wdata <= MData;
            if (hit_q) begin
              mem_we <= 1'b1;
              state  <= S_WR_MEM;
            end else if (cmd_q == MCMD_WRNP) begin
              SResp <= SRESP_ERR;
              state <= S_RESP;
            end else begin
              // Posted write outside the window is dropped without a response
              state <= S_IDLE;
            end
          end
        end
        S_WR_MEM: begin
          if (mem_ready) begin
            mem_we <= 1'b0;
            if (cmd_q == MCMD_WRNP) begin
              SResp <= SRESP_DVA;
              state <= S_RESP;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        S_RD_MEM: begin
          if (mem_ready) begin
            mem_re <= 1'b0;
            SData  <= mem_rdata;
            SResp  <= SRESP_DVA;
            state  <= S_RESP;
          end
        end
        S_RESP: begin
          SResp <= SRESP_NULL;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ocp_slave_fsm.sv
// Self-checking bench for ocp_slave_fsm: scoreboard queues for responses and local writes,
// plus per-scenario tasks with inline checks. Follows OCP_SLAVE_WRNP_EN like the design.
module tb_ocp_slave_fsm;

  localparam int          AW   = 64;
  localparam int          DW   = 8;
  localparam int          MAW  = 10;
  localparam logic [63:0] BASE = 64'h1000;
  localparam logic [63:0] WIN  = 64'd1024;

  localparam logic [2:0] C_IDLE = 3'b000;
  localparam logic [2:0] C_WR   = 3'b001;
  localparam logic [2:0] C_RD   = 3'b010;
  localparam logic [2:0] C_WRNP = 3'b101;
  localparam logic [2:0] C_BCST = 3'b111;
  localparam logic [1:0] R_NULL = 2'b00;
  localparam logic [1:0] R_DVA  = 2'b01;
  localparam logic [1:0] R_ERR  = 2'b11;

  typedef struct packed {
    logic [1:0]    resp;
    logic [DW-1:0] data;
    logic          chk_data;
  } resp_t;

  typedef struct packed {
    logic [MAW-1:0] addr;
    logic [DW-1:0]  data;
  } wr_t;

  logic           Clk = 1'b0;
  logic           reset;
  logic           EnableClk;
  logic [2:0]     MCmd;
  logic [AW-1:0]  MAddr;
  logic [DW-1:0]  MData;
  logic           MDataValid;
  logic           SCmdAccept;
  logic           SDataAccept;
  logic [1:0]     SResp;
  logic [DW-1:0]  SData;
  logic [MAW-1:0] mem_addr;
  logic [DW-1:0]  mem_wdata;
  logic           mem_we;
  logic           mem_re;
  logic [DW-1:0]  mem_rdata;
  logic           mem_ready;

  logic [DW-1:0]  tb_mem [0:1023];
  resp_t          exp_resp[$];
  wr_t            exp_wr[$];
  int             errors = 0;
  int             checks = 0;

  always #5 Clk = ~Clk;

  ocp_slave_fsm #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .MEM_ADDR_WIDTH (MAW),
    .BASE_ADDR      (BASE)
  ) dut (
    .Clk         (Clk),
    .reset       (reset),
    .EnableClk   (EnableClk),
    .MCmd        (MCmd),
    .MAddr       (MAddr),
    .MData       (MData),
    .MDataValid  (MDataValid),
    .SCmdAccept  (SCmdAccept),
    .SDataAccept (SDataAccept),
    .SResp       (SResp),
    .SData       (SData),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_we      (mem_we),
    .mem_re      (mem_re),
    .mem_rdata   (mem_rdata),
    .mem_ready   (mem_ready)
  );

  assign mem_rdata = tb_mem[mem_addr];

  always @(posedge Clk) begin
    if (mem_we && mem_ready) tb_mem[mem_addr] <= mem_wdata;
  end

  // Inputs are stable at the falling edge, so this sees exactly what the next enabled edge consumes
  always @(negedge Clk) begin
    if (reset && EnableClk) begin
      if (SResp !== R_NULL) begin
        checks++;
        if (exp_resp.size() == 0) begin
          errors++;
          $display("FAIL resp_unexpected: got SResp=%0d SData=%h, expected none", SResp, SData);
        end else begin
          resp_t e;
          e = exp_resp.pop_front();
          if (SResp !== e.resp || (e.chk_data && SData !== e.data)) begin
            errors++;
            $display("FAIL resp_scoreboard: got SResp=%0d SData=%h, expected SResp=%0d SData=%h",
                     SResp, SData, e.resp, e.data);
          end
        end
      end
      if (mem_we === 1'b1 && mem_ready) begin
        checks++;
        if (exp_wr.size() == 0) begin
          errors++;
          $display("FAIL write_unexpected: got addr=%0d data=%h, expected no write", mem_addr, mem_wdata);
        end else begin
          wr_t w;
          w = exp_wr.pop_front();
          if (mem_addr !== w.addr || mem_wdata !== w.data) begin
            errors++;
            $display("FAIL write_scoreboard: got addr=%0d data=%h, expected addr=%0d data=%h",
                     mem_addr, mem_wdata, w.addr, w.data);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic send_cmd(input logic [2:0] cmd, input logic [63:0] addr);
    int n = 0;
    MCmd  = cmd;
    MAddr = addr;
    #1;
    while (SCmdAccept !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (SCmdAccept !== 1'b1) begin
      errors++;
      $display("FAIL cmd_accept_timeout: got SCmdAccept=%b, expected 1", SCmdAccept);
    end
    tick();
    MCmd = C_IDLE;
  endtask

  task automatic send_data(input logic [DW-1:0] d);
    int n = 0;
    MData      = d;
    MDataValid = 1'b1;
    while (SDataAccept !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (SDataAccept !== 1'b1) begin
      errors++;
      $display("FAIL data_accept_timeout: got SDataAccept=%b, expected 1", SDataAccept);
    end
    tick();
    MDataValid = 1'b0;
  endtask

  task automatic wait_idle(output logic saw_data_accept);
    int n = 0;
    saw_data_accept = 1'b0;
    while (SCmdAccept !== 1'b1 && n < 30) begin
      if (SDataAccept === 1'b1) saw_data_accept = 1'b1;
      tick();
      n++;
    end
    checks++;
    if (SCmdAccept !== 1'b1) begin
      errors++;
      $display("FAIL idle_timeout: got SCmdAccept=%b, expected 1", SCmdAccept);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; EnableClk = 1'b1; MCmd = C_IDLE; MAddr = '0;
    MData = '0; MDataValid = 1'b0; mem_ready = 1'b1;
    tick(); tick();
    checks++;
    if ({SResp, SData, mem_addr, mem_wdata, mem_we, mem_re, SCmdAccept, SDataAccept} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got SResp=%0d SData=%h mem_addr=%0d we=%b re=%b acc=%b, expected all 0",
               SResp, SData, mem_addr, mem_we, mem_re, SCmdAccept);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (SCmdAccept !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_accept: got %b, expected 1", SCmdAccept);
    end
    // Abort a read stalled in the memory phase
    mem_ready = 1'b0;
    send_cmd(C_RD, BASE + 64'd5);
    checks++;
    if (mem_re !== 1'b1) begin
      errors++;
      $display("FAIL rd_mem_strobe: got mem_re=%b, expected 1", mem_re);
    end
    reset = 1'b0;
    tick(); tick();
    checks++;
    if (SResp !== R_NULL || mem_re !== 1'b0 || SCmdAccept !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_read: got SResp=%0d mem_re=%b acc=%b, expected 0 0 0", SResp, mem_re, SCmdAccept);
    end
    reset = 1'b1;
    mem_ready = 1'b1;
    #1;
    checks++;
    if (SCmdAccept !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_read_idle: got SCmdAccept=%b, expected 1", SCmdAccept);
    end
    tick(); tick();
  endtask

  task automatic test_write_hit();
    exp_wr.push_back('{addr: 10'd5, data: 8'hA5});
    send_cmd(C_WR, BASE + 64'd5);
    checks++;
    if (SDataAccept !== 1'b1) begin
      errors++;
      $display("FAIL wr_data_phase: got SDataAccept=%b, expected 1", SDataAccept);
    end
    send_data(8'hA5);
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 10'd5 || mem_wdata !== 8'hA5 || SResp !== R_NULL) begin
      errors++;
      $display("FAIL wr_hit_strobe: got we=%b addr=%0d data=%h SResp=%0d, expected 1 5 a5 0",
               mem_we, mem_addr, mem_wdata, SResp);
    end
    tick();
    checks++;
    if (mem_we !== 1'b0 || SCmdAccept !== 1'b1 || tb_mem[5] !== 8'hA5) begin
      errors++;
      $display("FAIL wr_hit_done: got we=%b acc=%b mem5=%h, expected 0 1 a5", mem_we, SCmdAccept, tb_mem[5]);
    end
  endtask

  task automatic test_read_hit(input logic [9:0] word, input logic [DW-1:0] val);
    tb_mem[word] = val;
    exp_resp.push_back('{resp: R_DVA, data: val, chk_data: 1'b1});
    send_cmd(C_RD, BASE + 64'(word));
    checks++;
    if (mem_re !== 1'b1 || SResp !== R_NULL) begin
      errors++;
      $display("FAIL rd_lat1: got mem_re=%b SResp=%0d, expected 1 0", mem_re, SResp);
    end
    tick();
    checks++;
    if (SResp !== R_DVA || SData !== val) begin
      errors++;
      $display("FAIL rd_lat2: got SResp=%0d SData=%h, expected 1 %h", SResp, SData, val);
    end
    tick();
    checks++;
    if (SResp !== R_NULL || SData !== val || SCmdAccept !== 1'b1) begin
      errors++;
      $display("FAIL rd_resp_width: got SResp=%0d SData=%h acc=%b, expected 0 %h 1", SResp, SData, SCmdAccept, val);
    end
  endtask

  task automatic test_miss();
    logic sda;
    exp_resp.push_back('{resp: R_ERR, data: '0, chk_data: 1'b0});
    send_cmd(C_RD, BASE + WIN);
    wait_idle(sda);
    exp_resp.push_back('{resp: R_ERR, data: '0, chk_data: 1'b0});
    send_cmd(C_RD, BASE - 64'd1);
    wait_idle(sda);
    exp_resp.push_back('{resp: R_ERR, data: '0, chk_data: 1'b0});
    send_cmd(C_BCST, BASE + 64'd1);
    wait_idle(sda);
    // Posted write outside the window: data phase only, no strobe, no response
    send_cmd(C_WR, BASE + WIN + 64'd3);
    send_data(8'h77);
    wait_idle(sda);
    checks++;
    if (mem_we !== 1'b0 || SResp !== R_NULL) begin
      errors++;
      $display("FAIL wr_miss: got we=%b SResp=%0d, expected 0 0", mem_we, SResp);
    end
    tick();
  endtask

  task automatic test_wait_enable();
    mem_ready = 1'b0;
    exp_wr.push_back('{addr: 10'd7, data: 8'h5A});
    send_cmd(C_WR, BASE + 64'd7);
    send_data(8'h5A);
    for (int i = 0; i < 3; i++) begin
      EnableClk = i[0];
      tick();
      checks++;
      if (mem_we !== 1'b1 || mem_addr !== 10'd7 || mem_wdata !== 8'h5A ||
          SCmdAccept !== 1'b0 || SDataAccept !== 1'b0) begin
        errors++;
        $display("FAIL wr_wait_hold%0d: got we=%b addr=%0d data=%h acc=%b dacc=%b, expected 1 7 5a 0 0",
                 i, mem_we, mem_addr, mem_wdata, SCmdAccept, SDataAccept);
      end
    end
    EnableClk = 1'b1;
    mem_ready = 1'b1;
    tick();
    checks++;
    if (mem_we !== 1'b0 || tb_mem[7] !== 8'h5A) begin
      errors++;
      $display("FAIL wr_wait_done: got we=%b mem7=%h, expected 0 5a", mem_we, tb_mem[7]);
    end
    // Read with wait states; then freeze the response cycle with EnableClk low
    mem_ready = 1'b0;
    exp_resp.push_back('{resp: R_DVA, data: 8'h5A, chk_data: 1'b1});
    send_cmd(C_RD, BASE + 64'd7);
    EnableClk = 1'b0;
    tick(); tick();
    EnableClk = 1'b1;
    tick();
    checks++;
    if (mem_re !== 1'b1 || SResp !== R_NULL) begin
      errors++;
      $display("FAIL rd_wait_hold: got re=%b SResp=%0d, expected 1 0", mem_re, SResp);
    end
    mem_ready = 1'b1;
    EnableClk = 1'b0;
    tick();
    EnableClk = 1'b1;
    tick();
    EnableClk = 1'b0;
    tick(); tick();
    checks++;
    if (SResp !== R_DVA || SData !== 8'h5A || SCmdAccept !== 1'b0) begin
      errors++;
      $display("FAIL resp_frozen: got SResp=%0d SData=%h acc=%b, expected 1 5a 0", SResp, SData, SCmdAccept);
    end
    EnableClk = 1'b1;
    tick();
    checks++;
    if (SResp !== R_NULL || SCmdAccept !== 1'b1) begin
      errors++;
      $display("FAIL resp_release: got SResp=%0d acc=%b, expected 0 1", SResp, SCmdAccept);
    end
  endtask

  task automatic test_wrnp();
    logic sda;
`ifdef OCP_SLAVE_WRNP_EN
    exp_wr.push_back('{addr: 10'd9, data: 8'hC3});
    exp_resp.push_back('{resp: R_DVA, data: '0, chk_data: 1'b0});
    send_cmd(C_WRNP, BASE + 64'd9);
    send_data(8'hC3);
    wait_idle(sda);
    checks++;
    if (tb_mem[9] !== 8'hC3) begin
      errors++;
      $display("FAIL wrnp_write: got mem9=%h, expected c3", tb_mem[9]);
    end
    exp_resp.push_back('{resp: R_ERR, data: '0, chk_data: 1'b0});
    send_cmd(C_WRNP, BASE + WIN);
    send_data(8'h11);
    wait_idle(sda);
`else
    tb_mem[9] = 8'h00;
    exp_resp.push_back('{resp: R_ERR, data: '0, chk_data: 1'b0});
    send_cmd(C_WRNP, BASE + 64'd9);
    MData = 8'hC3;
    MDataValid = 1'b1;
    wait_idle(sda);
    MDataValid = 1'b0;
    checks++;
    if (sda !== 1'b0 || tb_mem[9] !== 8'h00) begin
      errors++;
      $display("FAIL wrnp_disabled: got data_accept_seen=%b mem9=%h, expected 0 00", sda, tb_mem[9]);
    end
`endif
    tick();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) tb_mem[i] = '0;
    test_reset();
    test_write_hit();
    test_read_hit(10'd5, 8'hA5);
    test_read_hit(10'd5, 8'h3C);
    test_read_hit(10'd1023, 8'hE1);
    test_miss();
    test_wait_enable();
    test_wrnp();
    tick(); tick();
    checks++;
    if (exp_resp.size() != 0 || exp_wr.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d responses and %0d writes outstanding, expected 0 0",
               exp_resp.size(), exp_wr.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
